// File: rtl/hoop_game_pkg.sv
// Shared encodings for the hoop game controller: FSM states and play modes.
package hoop_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   localparam logic MODE_TIMED    = 1'b0;
   localparam logic MODE_PRACTICE = 1'b1;

endpackage

// File: rtl/hoop_game_ctrl_if.sv
// Control/status bundle between the hoop game controller and its surroundings.
interface hoop_game_ctrl_if #(
   parameter int unsigned NUM_HOOPS = 1,
   parameter int unsigned SCORE_W   = 8,
   parameter int unsigned TIME_W    = 8
);
   localparam int unsigned TOT_W = SCORE_W + $clog2(NUM_HOOPS) + 1;

   logic                           start;
   logic                           stop;
   logic                           mode;
   logic [NUM_HOOPS-1:0]           hoop_in;
   logic [1:0]                     state;
   logic [TIME_W-1:0]              time_left;
   logic [NUM_HOOPS*SCORE_W-1:0]   scores;
   logic [TOT_W-1:0]               total_score;
   logic [TOT_W-1:0]               high_score;
   logic [NUM_HOOPS-1:0]           score_pulse;
   logic                           game_over_pulse;

   modport master (
      output start, stop, mode, hoop_in,
      input  state, time_left, scores, total_score, high_score, score_pulse, game_over_pulse
   );

   modport slave (
      input  start, stop, mode, hoop_in,
      output state, time_left, scores, total_score, high_score, score_pulse, game_over_pulse
   );

endinterface

// File: rtl/hoop_debouncer.sv
// One hoop channel: 2-flop synchroniser, stable-sample counter, registered rising-edge strobe.
module hoop_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic rise_o
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter tracks consecutive samples disagreeing with the accepted level.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/hoop_game_ctrl.sv
// Hoop game controller: game FSM, 1 Hz prescaler, saturating per-hoop scores and high score.
module hoop_game_ctrl
   import hoop_game_pkg::*;
#(
   parameter int unsigned NUM_HOOPS       = 1,
   parameter int unsigned SCORE_W         = 8,
   parameter int unsigned TIME_W          = 8,
   parameter int unsigned GAME_SECONDS    = 10,
   parameter int unsigned TICKS_PER_SEC   = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input logic             clk_i,
   input logic             rst_i,
   hoop_game_ctrl_if.slave bus
);

   localparam int unsigned TOT_W   = SCORE_W + $clog2(NUM_HOOPS) + 1;
   localparam int unsigned PRESC_W = $clog2(TICKS_PER_SEC);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

   logic [NUM_HOOPS-1:0] rise;

   for (genvar i = 0; i < NUM_HOOPS; i++) begin : g_hoop
      hoop_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .raw_i  (bus.hoop_in[i]),
         .rise_o (rise[i])
      );
   end

   state_e                             state_q, state_d;
   logic                               mode_q, mode_d;
   logic [PRESC_W-1:0]                 presc_q, presc_d;
   logic [TIME_W-1:0]                  time_q, time_d;
   logic [NUM_HOOPS-1:0][SCORE_W-1:0]  scores_q, scores_d;
   logic [TOT_W-1:0]                   total_q, total_d;
   logic [TOT_W-1:0]                   high_q, high_d;
   logic [NUM_HOOPS-1:0]               pulse_q, pulse_d;
   logic                               gop_q, gop_d;
   logic                               sec_tick, expire;

   assign sec_tick = (state_q == ST_PLAY) && (presc_q == PRESC_MAX);
   assign expire   = sec_tick && (mode_q == MODE_TIMED) && (time_q == TIME_W'(1));

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      presc_d  = presc_q;
      time_d   = time_q;
      scores_d = scores_q;
      high_d   = high_q;
      pulse_d  = '0;
      gop_d    = 1'b0;
      total_d  = '0;

      unique case (state_q)
         ST_PLAY: begin
            presc_d = sec_tick ? '0 : presc_q + 1'b1;
            if (sec_tick) begin
               if (mode_q == MODE_TIMED) begin
                  time_d = time_q - 1'b1;
               end else if (time_q != '1) begin
                  time_d = time_q + 1'b1;
               end
            end
            // Baskets still count on the edge that ends the game.
            for (int i = 0; i < NUM_HOOPS; i++) begin
               if (rise[i]) begin
                  pulse_d[i] = 1'b1;
                  if (scores_q[i] != '1) begin
                     scores_d[i] = scores_q[i] + 1'b1;
                  end
               end
            end
            if (bus.stop || expire) begin
               state_d = ST_OVER;
               gop_d   = 1'b1;
            end
         end
         default: begin
            if (bus.start) begin
               state_d  = ST_PLAY;
               mode_d   = bus.mode;
               presc_d  = '0;
               scores_d = '0;
               time_d   = (bus.mode == MODE_PRACTICE) ? '0 : TIME_W'(GAME_SECONDS);
            end
         end
      endcase

      for (int i = 0; i < NUM_HOOPS; i++) begin
         total_d = total_d + TOT_W'(scores_d[i]);
      end
      if (gop_d && (total_d > high_q)) begin
         high_d = total_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_TIMED;
         presc_q  <= '0;
         time_q   <= '0;
         scores_q <= '0;
         total_q  <= '0;
         high_q   <= '0;
         pulse_q  <= '0;
         gop_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         presc_q  <= presc_d;
         time_q   <= time_d;
         scores_q <= scores_d;
         total_q  <= total_d;
         high_q   <= high_d;
         pulse_q  <= pulse_d;
         gop_q    <= gop_d;
      end
   end

   assign bus.state           = state_q;
   assign bus.time_left       = time_q;
   assign bus.scores          = scores_q;
   assign bus.total_score     = total_q;
   assign bus.high_score      = high_q;
   assign bus.score_pulse     = pulse_q;
   assign bus.game_over_pulse = gop_q;

endmodule
